rand_rr_server: RTL and testbench

// - Shares one 32-bit xorshift PRNG core among NREQ requesters with round-robin arbitration.
// - Sequences the core: seed load, warm-up discard, then on-demand word delivery.
// - Sits between the random sources (seed / entropy bit) and consumer blocks that need random words.

---
 rtl/rand_rr_server.sv | 156 +++++++++++++++
 tb/tb_rand_rr_server.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_rr_server.sv
// rand_rr_server
//   Shares one 32-bit xorshift generator among NREQ requesters using
//   round-robin arbitration. The sequence is: seed load, then a warm-up
//   discard, then on-demand word delivery.
//
//   Optional feature macro: RAND_SRV_ENTROPY_EN. When it is defined, the
//   iEntropy port exists and its bit is XORed into bit 0 of every
//   generator update.
//
// Ports
//   iCLK     in   clock (rising edge)
//   iRST_N   in   asynchronous active-low reset
//   iSeed    in   32-bit seed, sampled in LOAD
//   iReseed  in   reseed request, level-sampled every cycle
//   iReq     in   NREQ per-requester word requests (level)
//   oGnt     out  NREQ one-hot grant pulse, qualifies oData
//   oData    out  WS-bit random word (generator bits [31 -: WS])
//   oReady   out  high while in RUN
//   iEntropy in   external entropy bit (only with RAND_SRV_ENTROPY_EN)
module rand_rr_server #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned WS   = 16,
   parameter int unsigned WARM = 8
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   input  logic [31:0]     iSeed,
   input  logic            iReseed,
   input  logic [NREQ-1:0] iReq,
   output logic [NREQ-1:0] oGnt,
   output logic [WS-1:0]   oData,
   output logic            oReady
`ifdef RAND_SRV_ENTROPY_EN
   ,
   input  logic            iEntropy
`endif
);

   localparam int unsigned PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [31:0] DEF_SEED  = 32'h2545F491;
   localparam logic [7:0]  WARM_LAST = 8'((WARM > 0) ? WARM - 1 : 0);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_WARM = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t          state;
   logic [31:0]     x;
   logic [7:0]      cnt;
   logic [PW-1:0]   ptr;

   function automatic logic [31:0] xsStep(input logic [31:0] v);
      logic [31:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   logic entBit;
`ifdef RAND_SRV_ENTROPY_EN
   assign entBit = iEntropy;
`else
   assign entBit = 1'b0;
`endif

   logic [31:0] nextX;
   logic [31:0] loadX;
   assign nextX = xsStep(x) ^ {31'b0, entBit};
   assign loadX = (iSeed == 32'd0) ? DEF_SEED : iSeed;

   // Rotating priority search: candidate = (ptr + i) mod NREQ, first hit wins.
   logic          winFound;
   logic [PW-1:0] winIdx;
   logic [PW:0]   cand;

   always_comb begin
      winFound = 1'b0;
      winIdx   = '0;
      cand     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr} + (PW+1)'(i);
         if (cand >= (PW+1)'(NREQ))
            cand = cand - (PW+1)'(NREQ);
         if (!winFound && iReq[cand[PW-1:0]]) begin
            winFound = 1'b1;
            winIdx   = cand[PW-1:0];
         end
      end
   end

   logic [PW-1:0] nextPtr;
   assign nextPtr = (winIdx == PW'(NREQ - 1)) ? '0 : winIdx + PW'(1);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state  <= S_LOAD;
         x      <= DEF_SEED;
         cnt    <= '0;
         ptr    <= '0;
         oGnt   <= '0;
         oData  <= '0;
         oReady <= 1'b0;
      end else if (iReseed) begin
         // Reseed overrides any grant; held high keeps reloading in LOAD.
         state  <= S_LOAD;
         oGnt   <= '0;
         oReady <= 1'b0;
         if (state == S_LOAD) begin
            x   <= loadX;
            cnt <= '0;
         end
      end else begin
         case (state)
            S_LOAD: begin
               x    <= loadX;
               cnt  <= '0;
               oGnt <= '0;
               if (WARM == 0) begin
                  state  <= S_RUN;
                  oReady <= 1'b1;
               end else begin
                  state <= S_WARM;
               end
            end
            S_WARM: begin
               x    <= nextX;
               cnt  <= cnt + 8'd1;
               oGnt <= '0;
               if (cnt == WARM_LAST) begin
                  state  <= S_RUN;
                  oReady <= 1'b1;
               end
            end
            S_RUN: begin
               if (winFound) begin
                  oGnt  <= {{(NREQ-1){1'b0}}, 1'b1} << winIdx;
                  oData <= nextX[31 -: WS];
                  x     <= nextX;
                  ptr   <= nextPtr;
               end else begin
                  oGnt <= '0;
               end
            end
            default: begin
               state  <= S_LOAD;
               oGnt   <= '0;
               oReady <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rand_rr_server.sv
module tb_rand_rr_server;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] seed = 32'd1;
   logic        reseed = 1'b0;
   logic [3:0]  reqA = '0;
   logic [2:0]  reqB = '0;
   logic [3:0]  gntA;
   logic [2:0]  gntB;
   logic [31:0] dataA;
   logic [15:0] dataB;
   logic        readyA, readyB;

   always #5 clk = ~clk;

   // A: NREQ=4, WS=32, WARM=0.  B: NREQ=3, WS=16, WARM=8.
   rand_rr_server #(.NREQ(4), .WS(32), .WARM(0)) dutA (
      .iCLK(clk), .iRST_N(rst_n), .iSeed(seed), .iReseed(reseed),
      .iReq(reqA), .oGnt(gntA), .oData(dataA), .oReady(readyA)
`ifdef RAND_SRV_ENTROPY_EN
      , .iEntropy(1'b0)
`endif
   );

   rand_rr_server #(.NREQ(3), .WS(16), .WARM(8)) dutB (
      .iCLK(clk), .iRST_N(rst_n), .iSeed(seed), .iReseed(reseed),
      .iReq(reqB), .oGnt(gntB), .oData(dataB), .oReady(readyB)
`ifdef RAND_SRV_ENTROPY_EN
      , .iEntropy(1'b0)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: phase 0=loading, 1=discarding warm-up steps, 2=serving.
   typedef struct {
      int          phase;
      int          left;
      logic [31:0] x;
      int          ptr;
      logic        ready;
   } mdl_t;

   typedef struct {
      logic [7:0]  g;
      logic [31:0] x;
   } ev_t;

   mdl_t mA, mB;
   ev_t  qA[$];
   ev_t  qB[$];
   logic expReadyA = 1'b0, expReadyB = 1'b0;
   bit   monOn = 1'b0;

   function automatic logic [31:0] xs(input logic [31:0] v);
      logic [31:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 17);
      return t ^ (t << 5);
   endfunction

   function automatic mdl_t mReset();
      mdl_t m;
      m.phase = 0; m.left = 0; m.x = 32'h2545F491; m.ptr = 0; m.ready = 1'b0;
      return m;
   endfunction

   task automatic mstep(input int n, input int warmN, input logic [7:0] rq,
                        inout mdl_t m, output ev_t ev, output bit hit);
      logic [31:0] sv;
      sv  = (seed == 32'd0) ? 32'h2545F491 : seed;
      hit = 1'b0;
      ev.g = '0;
      ev.x = '0;
      if (reseed) begin
         if (m.phase == 0) m.x = sv;
         m.phase = 0;
         m.ready = 1'b0;
      end else if (m.phase == 0) begin
         m.x = sv;
         if (warmN == 0) begin m.phase = 2; m.ready = 1'b1; end
         else begin m.phase = 1; m.left = warmN; end
      end else if (m.phase == 1) begin
         m.x = xs(m.x);
         m.left--;
         if (m.left == 0) begin m.phase = 2; m.ready = 1'b1; end
      end else begin
         for (int k = 0; k < n; k++) begin
            int idx;
            idx = (m.ptr + k) % n;
            if (rq[idx]) begin
               m.x   = xs(m.x);
               ev.g  = 8'(1 << idx);
               ev.x  = m.x;
               m.ptr = (idx + 1) % n;
               hit   = 1'b1;
               break;
            end
         end
      end
   endtask

   // Predict the next rising edge from current inputs, then advance one cycle.
   task automatic cycle();
      ev_t ev;
      bit  hit;
      mstep(4, 0, {4'b0, reqA}, mA, ev, hit);
      if (hit) qA.push_back(ev);
      expReadyA = mA.ready;
      mstep(3, 8, {5'b0, reqB}, mB, ev, hit);
      if (hit) qB.push_back(ev);
      expReadyB = mB.ready;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever a DUT presents a grant.
   always @(posedge clk) begin
      ev_t e;
      #1;
      if (monOn) begin
         check("readyA", {31'b0, readyA}, {31'b0, expReadyA});
         check("readyB", {31'b0, readyB}, {31'b0, expReadyB});
         if (gntA != '0) begin
            if (qA.size() == 0) check("unexpectedGntA", {28'b0, gntA}, 32'd0);
            else begin
               e = qA.pop_front();
               check("gntA", {28'b0, gntA}, {24'b0, e.g});
               check("dataA", dataA, e.x);
            end
         end
         if (gntB != '0) begin
            if (qB.size() == 0) check("unexpectedGntB", {29'b0, gntB}, 32'd0);
            else begin
               e = qB.pop_front();
               check("gntB", {29'b0, gntB}, {24'b0, e.g});
               check("dataB", {16'b0, dataB}, {16'b0, e.x[31:16]});
            end
         end
      end
   end

   initial begin
      mA = mReset();
      mB = mReset();
      repeat (2) @(negedge clk);
      check("rstGntA", {28'b0, gntA}, 32'd0);
      check("rstDataA", dataA, 32'd0);
      check("rstReadyA", {31'b0, readyA}, 32'd0);
      check("rstReadyB", {31'b0, readyB}, 32'd0);
      rst_n = 1'b1;
      monOn = 1'b1;

      // Seed 1, single requester: known first words.
      seed = 32'd1; reqA = 4'b0001; reqB = 3'b001;
      cycle();
      cycle();
      check("t1word0", dataA, 32'h00042021);
      cycle();
      check("t1word1", dataA, 32'h04080601);
      repeat (10) cycle();

      // Full and partial rotation.
      reqA = 4'b1111; reqB = 3'b111;
      repeat (8) cycle();
      reqA = 4'b1010; reqB = 3'b101;
      repeat (4) cycle();

      // Zero seed selects the default constant; B warms up again.
      seed = 32'd0; reseed = 1'b1;
      cycle();
      reseed = 1'b0;
      repeat (14) cycle();

      // Reseed pulse mid-stream, then restart of the seed-1 sequence.
      seed = 32'd1; reqA = 4'b0001;
      reseed = 1'b1;
      cycle();
      check("t4gnt", {28'b0, gntA}, 32'd0);
      check("t4ready", {31'b0, readyA}, 32'd0);
      reseed = 1'b0;
      cycle();
      cycle();
      check("t4restart", dataA, 32'h00042021);

      // Held reseed keeps both instances in LOAD.
      reseed = 1'b1;
      repeat (3) cycle();
      reseed = 1'b0;

      // Randomised traffic with occasional reseeds and zero seeds.
      for (int i = 0; i < 400; i++) begin
         reqA   = 4'($urandom_range(0, 15));
         reqB   = 3'($urandom_range(0, 7));
         reseed = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 7) == 0) seed = 32'd0;
         else if (reseed) seed = $urandom;
         cycle();
      end
      reseed = 1'b0;
      reqA = 4'b1111; reqB = 3'b111;
      repeat (12) cycle();

      // Asynchronous reset between edges, right after a grant.
      monOn = 1'b0;
      rst_n = 1'b0;
      #1;
      check("asyncGntA", {28'b0, gntA}, 32'd0);
      check("asyncDataA", dataA, 32'd0);
      check("asyncReadyA", {31'b0, readyA}, 32'd0);
      check("asyncGntB", {29'b0, gntB}, 32'd0);
      check("asyncReadyB", {31'b0, readyB}, 32'd0);
      mA = mReset();
      mB = mReset();
      expReadyA = 1'b0; expReadyB = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      monOn = 1'b1;
      seed = 32'd1; reqA = 4'b0001; reqB = 3'b010;
      cycle();
      cycle();
      check("postRstWord", dataA, 32'h00042021);
      repeat (12) cycle();
      reqA = '0; reqB = '0;
      repeat (2) cycle();

      check("qA_drained", 32'(qA.size()), 32'd0);
      check("qB_drained", 32'(qB.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
